// File: rtl/k_and_s_pkg.sv
// Shared instruction-decode type for the K-and-S processor.
// The 5-bit code space leaves room for codes the control unit treats as no-ops.
package k_and_s_pkg;

    typedef enum logic [4:0] {
        I_NOP    = 5'd0,
        I_LOAD   = 5'd1,
        I_STORE  = 5'd2,
        I_MOVE   = 5'd3,
        I_ADD    = 5'd4,
        I_SUB    = 5'd5,
        I_AND    = 5'd6,
        I_OR     = 5'd7,
        I_BRANCH = 5'd8,
        I_BZERO  = 5'd9,
        I_BNZERO = 5'd10,
        I_BNEG   = 5'd11,
        I_BNNEG  = 5'd12,
        I_BOV    = 5'd13,
        I_BNOV   = 5'd14,
        I_HALT   = 5'd15
    } decoded_instruction_type;

endpackage

// File: rtl/control_unit_if.sv
// Bundle between the control unit and the data path.
// The master side is the control unit; the slave side is the data path.
interface control_unit_if #(
    parameter int COUNT_W = 16
);
    import k_and_s_pkg::*;

    decoded_instruction_type decoded_instruction;
    logic                    zero_op;
    logic                    neg_op;
    logic                    unsigned_overflow;
    logic                    signed_overflow;

    logic                    branch;
    logic                    pc_enable;
    logic                    ir_enable;
    logic                    addr_sel;
    logic                    c_sel;
    logic [1:0]              operation;
    logic                    write_reg_enable;
    logic                    flags_reg_enable;
    logic                    ram_write_enable;
    logic                    halt;
    logic [COUNT_W-1:0]      instr_count;

    modport master (
        input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
        output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
               write_reg_enable, flags_reg_enable, ram_write_enable, halt, instr_count
    );

    modport slave (
        output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
        input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
               write_reg_enable, flags_reg_enable, ram_write_enable, halt, instr_count
    );

endinterface

// File: rtl/control_unit.sv
// Multi-cycle control unit: FETCH -> DECODE -> EXEC per instruction, HALTED on I_HALT.
// Strobes are combinational from state, decode and flags; reset masks every strobe.
module control_unit
    import k_and_s_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    control_unit_if.master cu
);

    typedef enum logic [1:0] {
        FETCH,
        DECODE,
        EXEC,
        HALTED
    } state_t;

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;

    // The signed overflow flag feeds no branch condition.
    logic unusedSignedOverflow;
    assign unusedSignedOverflow = cu.signed_overflow;

    assign cu.instr_count = count_q;

    // State and retired-instruction counter; reset aborts whatever was in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next state, counter update and all strobes; anything not driven below stays 0.
    always_comb begin
        state_d             = state_q;
        count_d             = count_q;
        cu.branch           = 1'b0;
        cu.pc_enable        = 1'b0;
        cu.ir_enable        = 1'b0;
        cu.addr_sel         = 1'b0;
        cu.c_sel            = 1'b0;
        cu.operation        = 2'b00;
        cu.write_reg_enable = 1'b0;
        cu.flags_reg_enable = 1'b0;
        cu.ram_write_enable = 1'b0;
        cu.halt             = 1'b0;

        unique case (state_q)
            FETCH: begin
                cu.ir_enable = 1'b1;
                cu.pc_enable = 1'b1;
                state_d      = DECODE;
            end
            DECODE: begin
                if (cu.decoded_instruction == I_HALT) begin
                    state_d = HALTED;
                    count_d = count_q + 1'b1;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH;
                count_d = count_q + 1'b1;
                case (cu.decoded_instruction)
                    I_LOAD: begin
                        cu.addr_sel         = 1'b1;
                        cu.write_reg_enable = 1'b1;
                    end
                    I_STORE: begin
                        cu.addr_sel         = 1'b1;
                        cu.ram_write_enable = 1'b1;
                    end
                    I_MOVE: begin
                        cu.c_sel            = 1'b1;
                        cu.write_reg_enable = 1'b1;
                    end
                    I_ADD, I_SUB, I_AND, I_OR: begin
                        cu.c_sel            = 1'b1;
                        cu.write_reg_enable = 1'b1;
                        cu.flags_reg_enable = 1'b1;
                        case (cu.decoded_instruction)
                            I_ADD:   cu.operation = 2'b01;
                            I_SUB:   cu.operation = 2'b10;
                            I_AND:   cu.operation = 2'b11;
                            default: cu.operation = 2'b00;
                        endcase
                    end
                    I_BRANCH: begin
                        cu.pc_enable = 1'b1;
                        cu.branch    = 1'b1;
                    end
                    I_BZERO:  {cu.pc_enable, cu.branch} = {2{cu.zero_op}};
                    I_BNZERO: {cu.pc_enable, cu.branch} = {2{~cu.zero_op}};
                    I_BNEG:   {cu.pc_enable, cu.branch} = {2{cu.neg_op}};
                    I_BNNEG:  {cu.pc_enable, cu.branch} = {2{~cu.neg_op}};
                    I_BOV:    {cu.pc_enable, cu.branch} = {2{cu.unsigned_overflow}};
                    I_BNOV:   {cu.pc_enable, cu.branch} = {2{~cu.unsigned_overflow}};
                    default: ;
                endcase
            end
            HALTED: begin
                cu.halt = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        if (rst) begin
            cu.branch           = 1'b0;
            cu.pc_enable        = 1'b0;
            cu.ir_enable        = 1'b0;
            cu.addr_sel         = 1'b0;
            cu.c_sel            = 1'b0;
            cu.operation        = 2'b00;
            cu.write_reg_enable = 1'b0;
            cu.flags_reg_enable = 1'b0;
            cu.ram_write_enable = 1'b0;
            cu.halt             = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit with a scoreboard queue of expected outputs.
// A narrow counter keeps the wrap-around run short.
module tb_control_unit;
    import k_and_s_pkg::*;

    localparam int CW = 10;

    typedef struct {
        string          tag;
        logic [10:0]    strobes;
        logic [CW-1:0]  count;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    exp_t          scoreboard[$];
    int            vectorsApplied = 0;
    int            miscompares = 0;
    logic [CW-1:0] modelCount;

    control_unit_if #(.COUNT_W(CW)) cuIf ();

    control_unit #(.COUNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .cu  (cuIf)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Packs one expected strobe vector in the order the checker observes them.
    function automatic logic [10:0] mk(input logic br, input logic pc, input logic ir,
                                       input logic as, input logic cs, input logic [1:0] op,
                                       input logic wr, input logic fl, input logic ram,
                                       input logic hl);
        return {br, pc, ir, as, cs, op, wr, fl, ram, hl};
    endfunction

    // Expected EXEC-cycle strobes straight from the instruction table.
    function automatic logic [10:0] expExec(input decoded_instruction_type instr,
                                            input logic z, input logic n, input logic uo);
        logic take;
        take = 1'b0;
        case (instr)
            I_LOAD:   return mk(0, 0, 0, 1, 0, 2'b00, 1, 0, 0, 0);
            I_STORE:  return mk(0, 0, 0, 1, 0, 2'b00, 0, 0, 1, 0);
            I_MOVE:   return mk(0, 0, 0, 0, 1, 2'b00, 1, 0, 0, 0);
            I_ADD:    return mk(0, 0, 0, 0, 1, 2'b01, 1, 1, 0, 0);
            I_SUB:    return mk(0, 0, 0, 0, 1, 2'b10, 1, 1, 0, 0);
            I_AND:    return mk(0, 0, 0, 0, 1, 2'b11, 1, 1, 0, 0);
            I_OR:     return mk(0, 0, 0, 0, 1, 2'b00, 1, 1, 0, 0);
            I_BRANCH: return mk(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
            I_BZERO:  take = z;
            I_BNZERO: take = !z;
            I_BNEG:   take = n;
            I_BNNEG:  take = !n;
            I_BOV:    take = uo;
            I_BNOV:   take = !uo;
            default:  return '0;
        endcase
        return mk(take, take, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    endfunction

    task automatic applyStimulus(input decoded_instruction_type instr, input logic z,
                                 input logic n, input logic uo, input logic so);
        cuIf.decoded_instruction = instr;
        cuIf.zero_op             = z;
        cuIf.neg_op              = n;
        cuIf.unsigned_overflow   = uo;
        cuIf.signed_overflow     = so;
    endtask

    task automatic pushExpected(input string tag, input logic [10:0] s);
        exp_t e;
        e.tag     = tag;
        e.strobes = s;
        e.count   = modelCount;
        scoreboard.push_back(e);
    endtask

    // Pops the oldest expectation and compares it with what the DUT shows right now.
    task automatic checkOutput();
        exp_t        e;
        logic [10:0] obs;
        if (scoreboard.size() == 0) begin
            vectorsApplied++;
            miscompares++;
            $error("FAIL scoreboard: observed empty queue, required an entry");
            return;
        end
        e   = scoreboard.pop_front();
        obs = {cuIf.branch, cuIf.pc_enable, cuIf.ir_enable, cuIf.addr_sel, cuIf.c_sel,
               cuIf.operation, cuIf.write_reg_enable, cuIf.flags_reg_enable,
               cuIf.ram_write_enable, cuIf.halt};
        vectorsApplied++;
        assert (obs === e.strobes) else begin
            miscompares++;
            $error("FAIL %s strobes: observed %b required %b", e.tag, obs, e.strobes);
        end
        vectorsApplied++;
        assert (cuIf.instr_count === e.count) else begin
            miscompares++;
            $error("FAIL %s instr_count: observed %0d required %0d", e.tag,
                   cuIf.instr_count, e.count);
        end
    endtask

    // One full instruction starting just after an edge in FETCH; ends just after the
    // edge leaving EXEC (or entering HALTED).
    task automatic runInstr(input string tag, input decoded_instruction_type instr,
                            input logic z, input logic n, input logic uo, input logic so);
        pushExpected({tag, " fetch"}, mk(0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0));
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
        applyStimulus(instr, z, n, uo, so);
        pushExpected({tag, " decode"}, '0);
        @(negedge clk);
        checkOutput();
        if (instr != I_HALT) begin
            @(posedge clk);
            #1;
            pushExpected({tag, " exec"}, expExec(instr, z, n, uo));
            @(negedge clk);
            checkOutput();
        end
        @(posedge clk);
        #1;
        modelCount++;
    endtask

    task automatic quietNop();
        applyStimulus(I_NOP, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        modelCount++;
    endtask

    decoded_instruction_type condList[6] = '{I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV};

    // Directed sequence: reset, ALU/memory ops, branches, halt, wrap, reset mid-store.
    initial begin
        $display("[TB] control_unit bench start");
        rst        = 1'b1;
        modelCount = '0;
        applyStimulus(I_STORE, 1, 1, 1, 1);
        repeat (2) begin
            pushExpected("reset", '0);
            @(negedge clk);
            checkOutput();
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        runInstr("load", I_LOAD, 0, 0, 0, 0);
        runInstr("add", I_ADD, 0, 0, 0, 0);
        runInstr("sub", I_SUB, 1, 0, 0, 0);
        runInstr("and", I_AND, 0, 1, 0, 0);
        runInstr("or", I_OR, 0, 0, 1, 0);
        runInstr("move", I_MOVE, 1, 1, 1, 1);
        runInstr("store", I_STORE, 0, 0, 0, 0);
        runInstr("nop", I_NOP, 1, 1, 1, 1);
        runInstr("branch", I_BRANCH, 0, 0, 0, 0);
        runInstr("unlisted", decoded_instruction_type'(5'd23), 1, 1, 1, 1);

        foreach (condList[i]) begin
            runInstr({condList[i].name(), " flag1"}, condList[i], 1, 1, 1, 0);
            runInstr({condList[i].name(), " flag0"}, condList[i], 0, 0, 0, 1);
        end
        runInstr("bov signed only", I_BOV, 0, 0, 0, 1);

        runInstr("halt", I_HALT, 0, 0, 0, 0);
        applyStimulus(I_STORE, 1, 1, 1, 1);
        repeat (20) begin
            pushExpected("halted", mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1));
            @(negedge clk);
            checkOutput();
            @(posedge clk);
            #1;
        end

        rst        = 1'b1;
        modelCount = '0;
        #1;
        pushExpected("reset in halt", '0);
        checkOutput();
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 0; k < (2 ** CW) - 1; k++) quietNop();
        runInstr("nop at max", I_NOP, 0, 0, 0, 0);
        pushExpected("wrapped fetch", mk(0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0));
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
        applyStimulus(I_STORE, 0, 0, 0, 0);
        pushExpected("store decode", '0);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
        pushExpected("store exec", expExec(I_STORE, 0, 0, 0));
        @(negedge clk);
        checkOutput();
        #2;
        rst        = 1'b1;
        modelCount = '0;
        #1;
        pushExpected("reset in store", '0);
        checkOutput();
        @(posedge clk);
        #1;
        rst = 1'b0;
        runInstr("load after reset", I_LOAD, 0, 0, 0, 0);
        pushExpected("post reset fetch", mk(0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0));
        @(negedge clk);
        checkOutput();

        if (scoreboard.size() != 0) begin
            vectorsApplied++;
            miscompares++;
            $error("FAIL scoreboard drain: observed %0d left, required 0", scoreboard.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
